// File: rtl/vga_sync_rx_if.sv
// ---------------------------------------------------------------------------
// vga_sync_rx_if
// Purpose : video timing bundle between a sync source and vga_sync_rx.
// Signals : hsync/vsync (active low) and enable from the source;
//           hpos/vpos, locked, h_total/v_total, sync_err (and de_err when
//           VGA_SYNC_RX_DE_CHECK_EN is defined) from the receiver.
// Modports: master = source/observer side, slave = receiver side.
// ---------------------------------------------------------------------------
interface vga_sync_rx_if;
  localparam int unsigned CW = 14;

  logic          hsync;
  logic          vsync;
  logic          enable;
  logic [CW-1:0] hpos;
  logic [CW-1:0] vpos;
  logic          locked;
  logic [CW-1:0] h_total;
  logic [CW-1:0] v_total;
  logic          sync_err;
`ifdef VGA_SYNC_RX_DE_CHECK_EN
  logic          de_err;

  modport master (output hsync, vsync, enable,
                  input  hpos, vpos, locked, h_total, v_total, sync_err, de_err);
  modport slave  (input  hsync, vsync, enable,
                  output hpos, vpos, locked, h_total, v_total, sync_err, de_err);
`else
  modport master (output hsync, vsync, enable,
                  input  hpos, vpos, locked, h_total, v_total, sync_err);
  modport slave  (input  hsync, vsync, enable,
                  output hpos, vpos, locked, h_total, v_total, sync_err);
`endif
endinterface

// File: rtl/vga_sync_rx.sv
// ---------------------------------------------------------------------------
// vga_sync_rx
// Purpose : recovers hpos/vpos from sampled hsync/vsync with a flywheel
//           counter, measures line/frame length, reports lock and sync errors.
// Ports   : px_clk  - pixel clock, rising edge
//           rst_n   - asynchronous active-low reset
//           bus     - vga_sync_rx_if.slave (hsync, vsync, enable in;
//                     hpos, vpos, locked, h_total, v_total, sync_err out)
// Option  : VGA_SYNC_RX_DE_CHECK_EN adds bus.de_err, a one-cycle pulse in
//           LOCKED when the sampled enable disagrees with the predicted
//           active area.
// ---------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int unsigned WIDTH         = 640,
  parameter int unsigned H_FRONT_PORCH = WIDTH + 16,
  parameter int unsigned H_SIZE        = 800,
  parameter int unsigned HEIGHT        = 480,
  parameter int unsigned V_FRONT_PORCH = HEIGHT + 10,
  parameter int unsigned V_SIZE        = 525,
  parameter int unsigned LOCK_LINES    = 4
) (
  input logic          px_clk,
  input logic          rst_n,
  vga_sync_rx_if.slave bus
);
  localparam int unsigned   CW      = 14;
  localparam int unsigned   GW      = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] C_MAX   = '1;
  localparam logic [CW-1:0] C_HFP   = CW'(H_FRONT_PORCH);
  localparam logic [CW-1:0] C_HLAST = CW'(H_SIZE - 1);
  localparam logic [CW-1:0] C_VFP   = CW'(V_FRONT_PORCH);
  localparam logic [CW-1:0] C_VLAST = CW'(V_SIZE - 1);
  localparam logic [CW-1:0] C_TMO   = CW'(2 * H_SIZE);
  localparam logic [GW-1:0] C_LOCK  = GW'(LOCK_LINES);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [GW-1:0] r_good, w_good_nx;
  logic          r_locked, r_sync_err, w_sync_err_nx;
  logic          r_hs_d, r_vs_d, r_h_seen, r_v_seen;
  logic [CW-1:0] r_hpos, r_vpos, r_lcnt, r_fcnt, r_h_total, r_v_total;

  logic          w_h_fall, w_v_fall, w_wrap, w_h_mis, w_v_mis, w_timeout;
  logic [CW-1:0] w_nh, w_vinc, w_lcnt_inc, w_fcnt_inc;

  // Edge detect and flywheel prediction for the current sample
  assign w_h_fall   = r_hs_d & ~bus.hsync;
  assign w_v_fall   = r_vs_d & ~bus.vsync;
  assign w_nh       = (r_hpos == C_HLAST) ? '0 : r_hpos + CW'(1);
  assign w_wrap     = (w_nh == '0) & ~w_h_fall;
  assign w_vinc     = (r_vpos == C_VLAST) ? '0 : r_vpos + CW'(1);
  assign w_lcnt_inc = (r_lcnt == C_MAX) ? C_MAX : r_lcnt + CW'(1);
  assign w_fcnt_inc = (r_fcnt == C_MAX) ? C_MAX : r_fcnt + CW'(1);

  // Alignment: a sync edge must land where the flywheel expects it
  assign w_h_mis   = w_h_fall & (w_nh != C_HFP);
  assign w_v_mis   = w_v_fall & ((w_nh != '0) |
                                 ((r_state == S_LOCKED) & (w_vinc != C_VFP)));
  // Missing hsync: two line lengths without an edge
  assign w_timeout = (r_state != S_SEARCH) & ~w_h_fall & (w_lcnt_inc == C_TMO);

  // Next-state, aligned-line counter and error pulse
  always_comb begin
    w_state_nx    = r_state;
    w_good_nx     = r_good;
    w_sync_err_nx = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_h_fall) begin
          w_state_nx = S_ACQ;
          w_good_nx  = '0;
        end
      end
      S_ACQ: begin
        if (w_h_mis)
          w_good_nx = '0;
        else if (w_h_fall && (r_good != C_LOCK))
          w_good_nx = r_good + GW'(1);
        if (w_v_fall && (r_good >= C_LOCK) && (w_nh == '0))
          w_state_nx = S_LOCKED;
      end
      S_LOCKED: begin
        if (w_h_mis || w_v_mis) begin
          w_state_nx    = S_ACQ;
          w_good_nx     = '0;
          w_sync_err_nx = 1'b1;
        end else if (w_h_fall && (r_good != C_LOCK)) begin
          w_good_nx = r_good + GW'(1);
        end
      end
      default: w_state_nx = S_SEARCH;
    endcase
    if (w_timeout) begin
      w_state_nx    = S_SEARCH;
      w_good_nx     = '0;
      w_sync_err_nx = 1'b1;
    end
  end

  // State register and registered status outputs
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_SEARCH;
      r_good     <= '0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_good     <= w_good_nx;
      r_locked   <= (w_state_nx == S_LOCKED);
      r_sync_err <= w_sync_err_nx;
    end
  end

  // Flywheel position and line/frame measurement
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_lcnt    <= '0;
      r_fcnt    <= '0;
      r_h_total <= '0;
      r_v_total <= '0;
      r_h_seen  <= 1'b0;
      r_v_seen  <= 1'b0;
    end else begin
      r_hs_d <= bus.hsync;
      r_vs_d <= bus.vsync;
      r_hpos <= w_h_fall ? C_HFP : w_nh;
      if (w_v_fall)
        r_vpos <= C_VFP;
      else if (w_wrap)
        r_vpos <= w_vinc;

      if (w_h_fall) begin
        r_lcnt   <= '0;
        r_h_seen <= 1'b1;
        if (r_h_seen)
          r_h_total <= w_lcnt_inc;
      end else begin
        r_lcnt <= w_lcnt_inc;
      end

      // The wrap that coincides with vsync closes the frame being measured
      if (w_v_fall) begin
        r_fcnt   <= '0;
        r_v_seen <= 1'b1;
        if (r_v_seen)
          r_v_total <= w_wrap ? w_fcnt_inc : r_fcnt;
      end else if (w_wrap) begin
        r_fcnt <= w_fcnt_inc;
      end

      // Falling back to SEARCH restarts the "first edge only clears" rule
      if (w_timeout) begin
        r_h_seen <= 1'b0;
        r_v_seen <= 1'b0;
      end
    end
  end

  assign bus.hpos     = r_hpos;
  assign bus.vpos     = r_vpos;
  assign bus.locked   = r_locked;
  assign bus.h_total  = r_h_total;
  assign bus.v_total  = r_v_total;
  assign bus.sync_err = r_sync_err;

`ifdef VGA_SYNC_RX_DE_CHECK_EN
  localparam logic [CW-1:0] C_W = CW'(WIDTH);
  localparam logic [CW-1:0] C_H = CW'(HEIGHT);

  logic          r_de_err;
  logic [CW-1:0] w_nv;

  // Predicted line of this sample, before any vsync reload
  assign w_nv = w_wrap ? w_vinc : r_vpos;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n)
      r_de_err <= 1'b0;
    else
      r_de_err <= (r_state == S_LOCKED) &
                  (bus.enable != ((w_nh < C_W) & (w_nv < C_H)));
  end

  assign bus.de_err = r_de_err;
`else
  logic w_unused_enable;
  assign w_unused_enable = bus.enable;
`endif

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the VGA sync generator: samples hsync/vsync/enable and rebuilds hpos/vpos using a flywheel counter.
- Measures line and frame length and reports lock and sync errors.
- Sits at the far end of the video timing path: the sink for the generator in loop-back benches, and the front end for capture and check logic.

Parameters:
- WIDTH, 640, active pixels per line
- H_FRONT_PORCH, WIDTH+16, hpos at which hsync goes low
- H_SIZE, 800, total pixels per line
- HEIGHT, 480, active lines
- V_FRONT_PORCH, HEIGHT+10, vpos at which vsync goes low
- V_SIZE, 525, total lines per frame
- LOCK_LINES, 4, aligned hsync edges required before lock can be declared

Ports:
- px_clk  in  1  pixel clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- enable  in  1  data enable from source
- hpos  out  14  recovered horizontal position
- vpos  out  14  recovered vertical position
- locked  out  1  timing locked
- h_total  out  14  last measured line length in px_clk cycles
- v_total  out  14  last measured frame length in lines
- sync_err  out  1  one-cycle pulse on a misaligned or missing sync

Behaviour:
- Sampling
  - Inputs are sampled on the rising edge of px_clk; the source updates on the falling edge, so no synchroniser is needed.
  - hs_d and vs_d hold the previous samples; both reset to 1.
  - h_fall = hs_d & ~hsync; v_fall = vs_d & ~vsync.
- Latency: hpos/vpos valid in cycle n+1 describe the sample taken at edge n.
- Flywheel
  - nh = (hpos==H_SIZE-1) ? 0 : hpos+1.
  - On h_fall: hpos <= H_FRONT_PORCH; otherwise hpos <= nh.
  - vpos increments, wrapping V_SIZE-1 -> 0, whenever nh==0 and no h_fall.
  - On v_fall: vpos <= V_FRONT_PORCH.
  - If h_fall and v_fall occur together, both loads apply.
- Alignment checks
  - h_fall with nh != H_FRONT_PORCH is misaligned.
  - v_fall with nh != 0, or with vpos+1 (wrapped) != V_FRONT_PORCH while LOCKED, is misaligned.
- Measurement
  - lcnt counts cycles since the last h_fall. On h_fall: h_total <= lcnt+1 and lcnt <= 0.
  - fcnt counts nh==0 wraps since the last v_fall. On v_fall: v_total <= fcnt and fcnt <= 0.
  - Both counters saturate at 16383.
  - h_total and v_total update only after the second edge of their kind following reset or SEARCH; the first edge only clears the counter.
- State machine (encoding free)
  - SEARCH: entered on reset. First h_fall -> ACQ, with good=0.
  - ACQ: aligned h_fall increments good, saturating at LOCK_LINES. Misaligned h_fall sets good=0 and realigns hpos. v_fall with good>=LOCK_LINES and nh==0 -> LOCKED.
  - LOCKED: any misaligned h_fall or v_fall -> ACQ with good=0 and a sync_err pulse.
  - Any state other than SEARCH: lcnt reaching 2*H_SIZE -> SEARCH with a sync_err pulse. A timeout that coincides with an h_fall is not a timeout.
- Outputs
  - locked = (state==LOCKED), registered.
  - sync_err is high for exactly one cycle per event and is never asserted in SEARCH.
- Reset values: hpos=0, vpos=0, locked=0, h_total=0, v_total=0, sync_err=0; state=SEARCH; good, lcnt, fcnt all 0.
- Reset asserted mid-frame forces all of the above immediately; re-acquisition starts from scratch.

Optional Feature:
- Macro: VGA_SYNC_RX_DE_CHECK_EN.
- When defined:
  - Adds output de_err (1 bit, reset 0).
  - In LOCKED, de_err pulses for one cycle whenever the sampled enable != (nh<WIDTH && nvpos<HEIGHT), where nh/nvpos are the predicted position of that sample.
  - de_err is never asserted outside LOCKED, and does not affect state or sync_err.
- When undefined: no port and no logic.

Test Plan:
- Generator with default parameters from reset -> locked rises in the cycle after the sample where the generator shows hpos=0, vpos=490. hpos/vpos track the generator with 1-cycle latency, zero mismatches over 2 frames.
- Run 2 full frames -> h_total=800 and v_total=525 after the second v_fall; sync_err never asserted.
- While LOCKED, delay one hsync falling edge by 3 px_clk -> sync_err pulses one cycle, locked drops, hpos reloads to 656. Relock happens at the next v_fall, since good>=4 by then.
- Hold hsync high for 1600 cycles while LOCKED -> sync_err pulse at lcnt=1600, state SEARCH, locked=0. Restore the source -> relock at the next v_fall.
- Assert rst_n low mid-line (gen hpos=300, vpos=100) -> all outputs 0 immediately; after release, lock is regained at the next vpos=490.
- With VGA_SYNC_RX_DE_CHECK_EN defined, force enable low for 1 cycle at gen hpos=10, vpos=10 while LOCKED -> de_err pulses exactly one cycle and locked stays 1.
